// File: rtl/icache_2way_param_pkg.sv
// Shared types and helpers for the parametrised 2-way instruction cache.
package icache_2way_param_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMemRead,
    StFlushWalk
  } state_e;

  localparam int unsigned DefaultLineW = 128;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/icache_2way_param_way.sv
// One cache way: valid/tag/data arrays with lookup, fill write and per-set invalidate.
module icache_2way_param_way
  import icache_2way_param_pkg::*;
#(
  parameter int unsigned NumSets = 8,
  parameter int unsigned TagW    = 25,
  parameter int unsigned LineW   = DefaultLineW,
  localparam int unsigned IndexW = clog2(NumSets)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IndexW-1:0] rd_index_i,
  input  logic [TagW-1:0]   rd_tag_i,
  output logic              valid_o,
  output logic              hit_o,
  output logic [LineW-1:0]  line_o,
  input  logic              fill_en_i,
  input  logic [IndexW-1:0] fill_index_i,
  input  logic [TagW-1:0]   fill_tag_i,
  input  logic [LineW-1:0]  fill_line_i,
  input  logic              inv_en_i,
  input  logic [IndexW-1:0] inv_index_i
);

  logic [NumSets-1:0] valid_q;
  logic [TagW-1:0]    tag_q  [NumSets];
  logic [LineW-1:0]   data_q [NumSets];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_index_i] <= 1'b1;
    end else if (inv_en_i) begin
      valid_q[inv_index_i] <= 1'b0;
    end
  end

  // Tag and data need no reset: nothing reads them while valid is clear.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[fill_index_i]  <= fill_tag_i;
      data_q[fill_index_i] <= fill_line_i;
    end
  end

  assign valid_o = valid_q[rd_index_i];
  assign hit_o   = valid_o && (tag_q[rd_index_i] == rd_tag_i);
  assign line_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_2way_param.sv
// 2-way set-associative instruction cache with true LRU and a fence.i invalidate walk.
module icache_2way_param
  import icache_2way_param_pkg::*;
#(
  parameter int unsigned NUM_SETS       = 8,
  parameter int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned OFFSET_W = clog2(WORDS_PER_LINE) + 2,
  localparam int unsigned INDEX_W  = clog2(NUM_SETS),
  localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W,
  localparam int unsigned LINE_W   = 32 * WORDS_PER_LINE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  read_i,
  input  logic [31:0]           address_i,
  output logic [31:0]           instruction_o,
  output logic                  busywait_o,
  input  logic                  flush_i,
  output logic                  ins_mem_read_o,
  output logic [31-OFFSET_W:0]  ins_mem_address_o,
  input  logic [LINE_W-1:0]     ins_mem_instruction_i,
  input  logic                  ins_mem_busywait_i
);

  state_e               state_q;
  logic                 mem_read_q;
  logic [31-OFFSET_W:0] mem_addr_q;
  logic                 victim_q;
  logic                 flush_pend_q;
  logic [INDEX_W-1:0]   cnt_q;
  logic [NUM_SETS-1:0]  lru_q;

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [INDEX_W-1:0] mem_idx;
  logic [TAG_W-1:0]   mem_tag;
  logic               unused_addr_lsb;

  assign tag             = address_i[31 -: TAG_W];
  assign idx             = address_i[OFFSET_W +: INDEX_W];
  assign mem_idx         = mem_addr_q[INDEX_W-1:0];
  assign mem_tag         = mem_addr_q[INDEX_W +: TAG_W];
  assign unused_addr_lsb = ^address_i[1:0];

  logic              hit_w   [2];
  logic              valid_w [2];
  logic [LINE_W-1:0] line_w  [2];
  logic              fill_en;
  logic              inv_en;

  assign fill_en = (state_q == StMemRead) && !ins_mem_busywait_i;
  assign inv_en  = (state_q == StFlushWalk);

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_2way_param_way #(
      .NumSets (NUM_SETS),
      .TagW    (TAG_W),
      .LineW   (LINE_W)
    ) u_way (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .rd_index_i   (idx),
      .rd_tag_i     (tag),
      .valid_o      (valid_w[w]),
      .hit_o        (hit_w[w]),
      .line_o       (line_w[w]),
      .fill_en_i    (fill_en && (victim_q == 1'(w))),
      .fill_index_i (mem_idx),
      .fill_tag_i   (mem_tag),
      .fill_line_i  (ins_mem_instruction_i),
      .inv_en_i     (inv_en),
      .inv_index_i  (cnt_q)
    );
  end

  logic              hit_any;
  logic              hit;
  logic              hit_way;
  logic              victim;
  logic [LINE_W-1:0] hit_line;
  logic [31:0]       word_sel;

  assign hit_any  = hit_w[0] | hit_w[1];
  assign hit      = read_i & hit_any;
  assign hit_way  = ~hit_w[0];
  assign hit_line = hit_way ? line_w[1] : line_w[0];
  // Fill invalid ways first, in order, before consulting LRU.
  assign victim   = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_q[idx]);

  if (WORDS_PER_LINE > 1) begin : g_word_mux
    logic [OFFSET_W-3:0] word_idx;
    assign word_idx = address_i[OFFSET_W-1:2];
    assign word_sel = hit_line[word_idx*32 +: 32];
  end else begin : g_word_single
    assign word_sel = hit_line[31:0];
  end

  assign instruction_o = hit ? word_sel : 32'h0;

  logic busywait;
  always_comb begin
    busywait = 1'b0;
    unique case (state_q)
      StIdle:      busywait = read_i && !hit_any;
      StMemRead:   busywait = 1'b1;
      StFlushWalk: busywait = read_i;
      default:     busywait = 1'b0;
    endcase
  end

  // The idle-miss stall is combinational, so hold it low explicitly during reset.
  assign busywait_o        = rst_ni & busywait;
  assign ins_mem_read_o    = mem_read_q;
  assign ins_mem_address_o = mem_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      victim_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
      lru_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) lru_q[idx] <= ~hit_way;
          if (flush_i) begin
            state_q <= StFlushWalk;
          end else if (read_i && !hit_any) begin
            state_q    <= StMemRead;
            mem_read_q <= 1'b1;
            mem_addr_q <= {tag, idx};
            victim_q   <= victim;
          end
        end
        StMemRead: begin
          if (!ins_mem_busywait_i) begin
            mem_read_q     <= 1'b0;
            lru_q[mem_idx] <= ~victim_q;
            flush_pend_q   <= 1'b0;
            state_q        <= (flush_pend_q || flush_i) ? StFlushWalk : StIdle;
          end else if (flush_i) begin
            flush_pend_q <= 1'b1;
          end
        end
        StFlushWalk: begin
          lru_q[cnt_q] <= 1'b0;
          if (cnt_q == INDEX_W'(NUM_SETS - 1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/icache_2way_param.md
Name: icache_2way_param

Overview:
- Parametrised 2-way set-associative instruction cache; next generation of the direct-mapped 8-line instruction cache.
- Sits between the IF stage (PC as ADDRESS) and the instruction memory; returns one 32-bit word per fetch.
- Set count and line size are configurable. Adds true LRU replacement and a FLUSH (fence.i) invalidate walk.

Parameters:
- NUM_SETS, 8, number of sets; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 1.
- Derived (localparam):
  - OFFSET_W = log2(WORDS_PER_LINE)+2
  - INDEX_W = log2(NUM_SETS)
  - TAG_W = 32-INDEX_W-OFFSET_W
  - LINE_W = 32*WORDS_PER_LINE

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  fetch request from IF.
- ADDRESS  in  32  fetch byte address; bits [1:0] ignored.
- INSTRUCTION  out  32  fetched word; valid when READ=1 and BUSYWAIT=0.
- BUSYWAIT  out  1  stall to the pipeline.
- FLUSH  in  1  single-cycle pulse; invalidate the whole cache.
- INS_MEM_READ  out  1  line read request to instruction memory.
- INS_MEM_ADDRESS  out  32-OFFSET_W  line address {tag,index}.
- INS_MEM_INSTRUCTION  in  LINE_W  returned line; word 0 in bits [31:0].
- INS_MEM_BUSYWAIT  in  1  memory busy; line is valid in the cycle it is 0 while INS_MEM_READ=1.

Behaviour:
- Address split: tag=ADDRESS[31:32-TAG_W], index=ADDRESS[OFFSET_W+INDEX_W-1:OFFSET_W], word=ADDRESS[OFFSET_W-1:2].
- Per set: 2 ways × {valid, tag, line}, plus 1 LRU bit (names the least-recently-used way).
- Reset (RESET=0, asynchronous):
  - All valid bits and LRU bits cleared; state=IDLE; flush-pending cleared; index counter=0.
  - INS_MEM_READ=0, INS_MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=0 while RESET=0.
  - Reset mid-fill abandons the fill: INS_MEM_READ drops immediately and no line is written.
- Lookup is combinational. hit = READ and any way valid with matching tag.
- States:
  - IDLE:
    - READ=0: BUSYWAIT=0, no memory traffic.
    - Hit: INSTRUCTION=selected word, BUSYWAIT=0 in the same cycle (zero-wait). At the edge, LRU[index] is set to the other way.
    - Miss: BUSYWAIT=1 combinationally. At the edge, latch {tag,index} into INS_MEM_ADDRESS, choose the victim, and go to MEM_READ.
    - Victim choice: way 0 if invalid, else way 1 if invalid, else the way named by LRU.
  - MEM_READ:
    - INS_MEM_READ=1, BUSYWAIT=1; INS_MEM_ADDRESS held from the latch.
    - At an edge with INS_MEM_BUSYWAIT=0: write line, tag and valid into the victim; set LRU to the non-victim way; drop INS_MEM_READ.
    - Then go to FLUSH_WALK if flush is pending, else IDLE.
    - The next IDLE cycle re-looks-up and hits. Miss penalty = memory latency + 1 cycle.
  - FLUSH_WALK:
    - BUSYWAIT=1 while READ=1.
    - Clears valid (both ways) and LRU of set[counter], one set per cycle.
    - Leaves after set NUM_SETS-1, with counter wrapping to 0. Takes exactly NUM_SETS cycles.
- FLUSH handling:
  - FLUSH in IDLE enters FLUSH_WALK at the next edge; a simultaneous hit still returns its word that cycle.
  - FLUSH in MEM_READ sets flush-pending; the fill completes first, then the walk runs.
  - FLUSH during FLUSH_WALK is ignored.
- ADDRESS and READ must be held stable by IF while BUSYWAIT=1. Fills use the latched tag/index, so the fill is correct even if they change.
- INSTRUCTION=0 when there is no hit.

Decomposition:
- definitions.v holds:
  - state encodings IDLE/MEM_READ/FLUSH_WALK;
  - a clog2 function for the derived widths;
  - a default line width constant.
- Sub-module icache_way (instantiated twice): one way's valid/tag/data arrays with read port, tag compare and hit output, fill write port, and per-set invalidate port.
- The top level holds the FSM, LRU array, victim select, flush counter and word mux.

Test Plan (defaults: 8 sets, 4 words; line address = ADDRESS[31:4]):
- Cold miss:
  - READ=1, ADDRESS=0x00000000, memory busy 3 cycles, returns line {0x00400093,0x00300093,0x00200093,0x00100093}.
  - Expect BUSYWAIT=1, INS_MEM_READ=1, INS_MEM_ADDRESS=0x0000000; after the fill, INSTRUCTION=0x00100093.
  - Then ADDRESS=0x4 hits with 0x00200093, BUSYWAIT=0, no INS_MEM_READ.
- LRU eviction:
  - Fill 0x000 and 0x080 (set 0, both ways), then hit 0x080.
  - Access 0x100: evicts 0x000's way, INS_MEM_ADDRESS=0x0000010.
  - Afterwards 0x080 hits and 0x000 misses.
- Flush:
  - With 0x000 and 0x010 resident, pulse FLUSH in IDLE.
  - Expect BUSYWAIT=1 for exactly 8 cycles; 0x000 then misses.
- Flush during fill:
  - Pulse FLUSH in the 2nd MEM_READ cycle.
  - Fill completes, 8-cycle walk follows, then the refetch of the same address misses.
- Reset mid-fill:
  - Drive RESET=0 during MEM_READ.
  - INS_MEM_READ=0 and BUSYWAIT=0 immediately, without waiting for a CLK edge.
  - After release, the previously resident 0x080 misses.
- Idle:
  - READ=0 for 10 cycles with a changing ADDRESS.
  - BUSYWAIT=0, INS_MEM_READ never asserted, LRU unchanged.
